// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file write-back types and constants.
package rf_pkg;
    localparam int REG_IDX_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular write-back queue with ordered dual push, single pop and age-ordered entry view.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_a,
    input  wb_entry_t              data_a,
    input  logic                   push_b,
    input  wb_entry_t              data_b,
    input  logic                   pop,
    output logic [AW:0]            count,
    output wb_entry_t [DEPTH-1:0]  entries,
    output logic [DEPTH-1:0]       valid
);
    wb_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    // push_a is older than push_b, so it takes the lower slot when both fire
    always_ff @(posedge clk) begin
        if (push_a || push_b) mem[wr_ptr] <= push_a ? data_a : data_b;
        if (push_a && push_b) mem[wr_ptr + AW'(1)] <= data_b;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_a) + AW'(push_b);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push_a) + (AW+1)'(push_b) - (AW+1)'(pop);
        end
    end
    // entries[0] is the head (oldest); higher indices are progressively newer
    for (genvar i = 0; i < DEPTH; i++) begin : g_view
        assign entries[i] = mem[rd_ptr + AW'(i)];
        assign valid[i]   = (AW+1)'(i) < count;
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges load and ALU write-backs into one ordered register-file write stream
// with a newest-first lookup over pending writes.
module regfile_write_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    output logic        RegWr,
    output logic [4:0]  Rw,
    output logic [31:0] busW,
    input  logic [4:0]  q_reg,
    output logic        q_hit,
    output logic [31:0] q_data,
    output logic        busy
);
    localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
    logic [AW:0] count;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0] valid;
    logic push_a, push_b, pop;
    // readiness ignores a same-cycle pop so it depends only on registered count
    assign mem_ready = count <= LAST;
    assign alu_ready = count + (AW+1)'(mem_valid) <= LAST;
    assign push_a = mem_valid && mem_ready && mem_rd != REG_ZERO;
    assign push_b = alu_valid && alu_ready && alu_rd != REG_ZERO;
    assign pop = count != '0;
    assign busy = pop || RegWr;
    wb_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_a  (push_a),
        .data_a  ('{rd: mem_rd, data: mem_data}),
        .push_b  (push_b),
        .data_b  ('{rd: alu_rd, data: alu_data}),
        .pop     (pop),
        .count   (count),
        .entries (entries),
        .valid   (valid)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWr <= 1'b0;
            Rw    <= '0;
            busW  <= '0;
        end else begin
            RegWr <= pop;
            if (pop) begin
                Rw   <= entries[0].rd;
                busW <= entries[0].data;
            end
        end
    end
    // scan oldest to newest so the newest match wins
    always_comb begin
        q_hit  = RegWr && Rw == q_reg;
        q_data = q_hit ? busW : '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (valid[j] && entries[j].rd == q_reg) begin
                q_hit  = 1'b1;
                q_data = entries[j].data;
            end
        end
        if (q_reg == REG_ZERO) begin
            q_hit  = 1'b0;
            q_data = '0;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: scoreboard bench; stimulus queues expected writes, a monitor checks each RegWr cycle.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0, alu_valid = 1'b0;
    logic [4:0]  mem_rd = '0, alu_rd = '0, q_reg = '0;
    logic [31:0] mem_data = '0, alu_data = '0;
    logic        mem_ready, alu_ready, RegWr, q_hit, busy;
    logic [4:0]  Rw;
    logic [31:0] busW, q_data;
    logic [36:0] sb [$];
    logic [31:0] rf [32];
    int total = 0, passed = 0;
    int mcnt, mi, ai;
    logic em, ea;

    regfile_write_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .RegWr(RegWr), .Rw(Rw), .busW(busW),
        .q_reg(q_reg), .q_hit(q_hit), .q_data(q_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [36:0] act, input logic [36:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", n, act, exp);
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && RegWr) begin
            if (sb.size() == 0) chk("unexpected_write", {Rw, busW}, '0);
            else chk("write_order", {Rw, busW}, sb.pop_front());
            rf[Rw] = busW;
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = '0;
        // reset state
        cyc();
        chk("rst_regwr", RegWr, 1'b0);
        chk("rst_rw", Rw, 5'd0);
        chk("rst_busw", busW, 32'd0);
        chk("rst_mem_ready", mem_ready, 1'b1);
        chk("rst_alu_ready", alu_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        cyc();
        // single ALU write
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        sb.push_back({5'd5, 32'hDEADBEEF});
        #1 chk("t1_alu_ready", alu_ready, 1'b1);
        cyc();
        alu_valid = 0; q_reg = 5;
        #1 chk("t1_qhit_queued", {q_hit, q_data}, {1'b1, 32'hDEADBEEF});
        chk("t1_no_early_write", RegWr, 1'b0);
        cyc();
        chk("t1_regwr", {RegWr, Rw, busW}, {1'b1, 5'd5, 32'hDEADBEEF});
        chk("t1_qhit_inflight", q_hit, 1'b1);
        cyc();
        chk("t1_one_cycle", RegWr, 1'b0);
        chk("t1_rf5", rf[5], 32'hDEADBEEF);
        chk("t1_qhit_gone", {q_hit, q_data}, {1'b0, 32'd0});
        // same-cycle mem and alu to r3
        mem_valid = 1; mem_rd = 3; mem_data = 32'h11;
        alu_valid = 1; alu_rd = 3; alu_data = 32'h22;
        sb.push_back({5'd3, 32'h11});
        sb.push_back({5'd3, 32'h22});
        #1 chk("t2_ready", {mem_ready, alu_ready}, 2'b11);
        cyc();
        mem_valid = 0; alu_valid = 0; q_reg = 3;
        #1 chk("t2_q_both_queued", {q_hit, q_data}, {1'b1, 32'h22});
        cyc();
        chk("t2_first", busW, 32'h11);
        chk("t2_q_newest", q_data, 32'h22);
        cyc();
        chk("t2_second", busW, 32'h22);
        chk("t2_q_inflight", q_data, 32'h22);
        cyc();
        chk("t2_idle", {RegWr, q_hit}, 2'b00);
        chk("t2_rf3", rf[3], 32'h22);
        // rd=0 is accepted but dropped
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
        #1 chk("t3_ready", alu_ready, 1'b1);
        cyc();
        alu_valid = 0; q_reg = 0;
        #1 chk("t3_q_zero", {q_hit, q_data}, {1'b0, 32'd0});
        chk("t3_busy", busy, 1'b0);
        cyc();
        chk("t3_no_write", RegWr, 1'b0);
        // both valids held for 6 cycles
        mcnt = 0; mi = 0; ai = 0;
        for (int c = 0; c < 6; c++) begin
            mem_valid = 1; mem_rd = 5'(10 + mi); mem_data = 32'h100 + mi;
            alu_valid = 1; alu_rd = 5'(20 + ai); alu_data = 32'h200 + ai;
            em = mcnt <= 3;
            ea = mcnt + 1 <= 3;
            #1 chk("t4_mem_ready", mem_ready, em);
            chk("t4_alu_ready", alu_ready, ea);
            if (em) begin sb.push_back({mem_rd, mem_data}); mi++; end
            if (ea) begin sb.push_back({alu_rd, alu_data}); ai++; end
            mcnt = mcnt + int'(em) + int'(ea) - int'(mcnt > 0);
            cyc();
        end
        mem_valid = 0; alu_valid = 0;
        repeat (6) cyc();
        chk("t4_drained", {busy, 32'(sb.size())}, '0);
        // async reset with entries queued
        for (int c = 0; c < 2; c++) begin
            mem_valid = 1; mem_rd = 5'(11 + c); mem_data = 32'h300 + c;
            alu_valid = 1; alu_rd = 5'(21 + c); alu_data = 32'h400 + c;
            sb.push_back({mem_rd, mem_data});
            sb.push_back({alu_rd, alu_data});
            cyc();
        end
        mem_valid = 0; alu_valid = 0;
        #1 chk("t5_busy_before", busy, 1'b1);
        rst_n = 0;
        #1 chk("t5_rst_regwr", RegWr, 1'b0);
        chk("t5_rst_busy", busy, 1'b0);
        sb.delete();
        #1 rst_n = 1;
        repeat (4) cyc();
        chk("t5_no_writes", {busy, RegWr}, 2'b00);
        // 8 back-to-back ALU writes
        for (int i = 1; i <= 8; i++) begin
            alu_valid = 1; alu_rd = 5'(i); alu_data = 32'h1000 + i;
            sb.push_back({alu_rd, alu_data});
            #1 chk("t6_alu_ready", alu_ready, 1'b1);
            chk("t6_stream", RegWr, i >= 3);
            cyc();
        end
        alu_valid = 0;
        chk("t6_tail7", {RegWr, Rw}, {1'b1, 5'd7});
        cyc();
        chk("t6_tail8", {RegWr, Rw}, {1'b1, 5'd8});
        cyc();
        chk("t6_end", RegWr, 1'b0);
        chk("t6_rf8", rf[8], 32'h1008);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Writer-side front end for the 32x32 register file, which has a single write port (`RegWr`/`Rw`/`busW`) sampled on negedge `clk`.
- Collects write-back requests from two producers, queues them in order, and issues at most one register-file write per cycle:
  - ALU path: single-cycle results.
  - Load path: multi-cycle memory returns.
- Provides a pending-write lookup so decode/forwarding logic can read values not yet committed to the register file.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- AW, 2, log2(DEPTH) pointer width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- mem_valid  input  1  load result offered.
- mem_rd  input  5  load destination register.
- mem_data  input  32  load result.
- mem_ready  output  1  load path accepted when mem_valid&&mem_ready at posedge.
- alu_valid  input  1  ALU result offered.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- alu_ready  output  1  ALU path accepted when alu_valid&&alu_ready at posedge.
- RegWr  output  1  register-file write enable, registered.
- Rw  output  5  register-file write index, registered.
- busW  output  32  register-file write data, registered.
- q_reg  input  5  lookup index.
- q_hit  output  1  a pending or in-flight write to q_reg exists; combinational.
- q_data  output  32  data of the newest matching write; 0 when !q_hit.
- busy  output  1  queue non-empty or RegWr=1.

Behaviour:
- Reset (async, rst_n=0):
  - Queue emptied; count=0.
  - RegWr=0, Rw=0, busW=0.
  - mem_ready=1, alu_ready=1.
  - A reset asserted mid-operation discards all queued and in-flight writes; no partial write occurs after rst_n falls.
- Ready rules: both are derived from registered count only. A dequeue in the same cycle is not credited.
  - mem_ready = (count <= DEPTH-1).
  - alu_ready = (count + (mem_valid ? 1 : 0) <= DEPTH-1).
- Enqueue order when both paths are accepted in the same cycle: load entry first (older in program order), then ALU entry.
- Register 0: a handshake with rd=0 completes normally, but the entry is dropped. It is never stored, never written, and never matched by lookup.
- Dequeue: at each posedge with count>0, the head is popped into RegWr/Rw/busW with RegWr=1. With count=0, RegWr=0; Rw/busW hold their last values.
- Latency: an entry accepted at posedge N into an empty queue drives RegWr=1 from posedge N+1 for exactly one cycle. The register file commits it at the following negedge.
- Throughput: 1 write per cycle sustained. A burst of k entries produces k consecutive RegWr=1 cycles.
- Simultaneous enqueue and dequeue in the same cycle are both legal. The count update is enqueues minus dequeue.
- Pointers wrap modulo DEPTH. Full (count=DEPTH) is never exceeded; empty pops never occur.
- Lookup search set: all valid queue entries plus the output register when RegWr=1.
  - Priority is newest first: the queue tail is newest and the output register is oldest.
  - q_reg=0 gives q_hit=0.
  - Same-cycle incoming requests are not included.
- Duplicate rd values in the queue are legal. All writes are issued in order, so the final register-file value is the newest.

Decomposition:
- Shared package rf_pkg:
  - REG_IDX_W=5, DATA_W=32, REG_ZERO=5'd0.
  - struct wb_entry_t {rd[4:0], data[31:0]}.
- Sub-module wb_fifo: DEPTH-entry circular buffer with dual-push (ordered) and single-pop. It exposes count and a flat entry/valid vector for the lookup.
- The lookup priority mux stays in the top module.

Test Plan:
- Reset, then a single ALU write rd=5, data=0xDEADBEEF at edge 1 -> RegWr=1, Rw=5, busW=0xDEADBEEF during cycle 2 only; register file r5=0xDEADBEEF after that negedge.
- Same-cycle mem(rd=3, 0x11) and alu(rd=3, 0x22) -> two consecutive writes, 0x11 then 0x22. q_reg=3 returns 0x22 while both are pending and 0x11 on neither. Final r3=0x22.
- Write with rd=0, data=0xFFFFFFFF -> handshake completes, RegWr stays 0, q_hit=0 for q_reg=0.
- Hold both valids for 6 cycles with DEPTH=4:
  - mem_ready falls when count=4; alu_ready falls at count>=3 whenever mem_valid=1.
  - No entry is lost or duplicated, and issue order matches accept order across pointer wrap.
- Pulse rst_n low asynchronously (mid-cycle) with 3 entries queued -> RegWr=0 immediately, busy=0, no further writes after release.
- Back-to-back 8 ALU writes rd=1..8 with no stalls -> RegWr high for 8 consecutive cycles, count never exceeds 1, alu_ready stays 1.
